fmul_iter: RTL and testbench

FMUL_ITER -- requirements
Module: fmul_iter

---
 rtl/fmul_pkg.sv | 36 +++
 rtl/fmul_round.sv | 106 ++++++++++
 rtl/fmul_iter.sv | 192 +++++++++++++++++++
 tb/tb_fmul_iter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// Shared definitions for the iterative floating-point multiplier.
// Holds the FSM state encoding, rounding-mode encodings, flag bit positions
// and helpers that derive the exponent bias and canonical quiet NaN from the
// exponent/fraction widths.
package fmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RND  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RM_RZ  = 2'b00,
        RM_RNE = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rmode_e;

    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Exponent bias for an ew-bit exponent field: 2^(ew-1) - 1.
    function automatic logic [31:0] fmul_bias(input int ew);
        return (32'd1 << (ew - 1)) - 32'd1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only.
    function automatic logic [63:0] fmul_qnan(input int ew, input int mw);
        return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
    endfunction

endpackage

// File: rtl/fmul_round.sv
// Combinational normalise-and-round stage.
// Ports:
//   sign_i   - product sign
//   exp_i    - biased exponent sum before normalisation (signed, EW+2 bits)
//   prod_i   - raw 2*(MW+1)-bit significand product, value in [1,4)
//   rm_i     - rounding mode (RZ, RNE, RM, RP)
//   result_o - rounded, packed result (overflow/underflow already resolved)
//   flags_o  - {NV, OF, UF, NX}
module fmul_round
    import fmul_pkg::*;
#(
    parameter int EW = 5,
    parameter int MW = 10
) (
    input  logic                 sign_i,
    input  logic signed [EW+1:0] exp_i,
    input  logic [2*MW+1:0]      prod_i,
    input  logic [1:0]           rm_i,
    output logic [EW+MW:0]       result_o,
    output logic [3:0]           flags_o
);

    localparam int PW = 2 * (MW + 1);
    localparam logic signed [EW+1:0] EXP_ONE  = {{(EW + 1){1'b0}}, 1'b1};
    localparam logic signed [EW+1:0] EXP_ZERO = {(EW + 2){1'b0}};
    localparam logic signed [EW+1:0] EXP_MAX  = {2'b00, {EW{1'b1}}};

    logic                 guard_s;
    logic                 sticky_s;
    logic                 inc_s;
    logic                 inexact_s;
    logic                 ovf_inf_s;
    logic [MW-1:0]        mant_s;
    logic [MW-1:0]        frac_s;
    logic [MW+1:0]        mant_rnd_s;
    logic signed [EW+1:0] exp_adj_s;
    logic signed [EW+1:0] exp_fin_s;

    // Normalise, pick guard/sticky, round, and resolve overflow/underflow.
    always_comb begin
        // A product MSB means the value is in [2,4): take one more bit off the
        // bottom and bump the exponent.
        if (prod_i[PW-1]) begin
            mant_s    = prod_i[PW-2 -: MW];
            guard_s   = prod_i[MW];
            sticky_s  = |prod_i[MW-1:0];
            exp_adj_s = exp_i + EXP_ONE;
        end else begin
            mant_s    = prod_i[PW-3 -: MW];
            guard_s   = prod_i[MW-1];
            sticky_s  = |prod_i[MW-2:0];
            exp_adj_s = exp_i;
        end

        inexact_s = guard_s | sticky_s;

        case (rm_i)
            RM_RZ:   inc_s = 1'b0;
            RM_RNE:  inc_s = guard_s & (sticky_s | mant_s[0]);
            RM_RDN:  inc_s = sign_i & inexact_s;
            RM_RUP:  inc_s = ~sign_i & inexact_s;
            default: inc_s = 1'b0;
        endcase

        // Overflow goes to infinity for RNE and for the directed mode that
        // rounds away from zero for this sign.
        case (rm_i)
            RM_RZ:   ovf_inf_s = 1'b0;
            RM_RNE:  ovf_inf_s = 1'b1;
            RM_RDN:  ovf_inf_s = sign_i;
            RM_RUP:  ovf_inf_s = ~sign_i;
            default: ovf_inf_s = 1'b1;
        endcase

        mant_rnd_s = {2'b01, mant_s} + {{(MW + 1){1'b0}}, inc_s};

        // Carry out of the rounded significand: value became exactly 2.0.
        if (mant_rnd_s[MW+1]) begin
            exp_fin_s = exp_adj_s + EXP_ONE;
            frac_s    = mant_rnd_s[MW:1];
        end else begin
            exp_fin_s = exp_adj_s;
            frac_s    = mant_rnd_s[MW-1:0];
        end

        flags_o = 4'b0000;
        if (exp_fin_s >= EXP_MAX) begin
            flags_o[FLAG_OF] = 1'b1;
            flags_o[FLAG_NX] = 1'b1;
            if (ovf_inf_s) begin
                result_o = {sign_i, {EW{1'b1}}, {MW{1'b0}}};
            end else begin
                result_o = {sign_i, {(EW - 1){1'b1}}, 1'b0, {MW{1'b1}}};
            end
        end else if (exp_fin_s <= EXP_ZERO) begin
            // No subnormal outputs: flush to signed zero.
            flags_o[FLAG_UF] = 1'b1;
            flags_o[FLAG_NX] = 1'b1;
            result_o = {sign_i, {(EW + MW){1'b0}}};
        end else begin
            flags_o[FLAG_NX] = inexact_s;
            result_o = {sign_i, exp_fin_s[EW-1:0], frac_s};
        end
    end

endmodule

// File: rtl/fmul_iter.sv
// Iterative IEEE-754 style multiplier with fixed latency.
// One operation at a time: accept in IDLE, MW+1 shift-add cycles in MUL,
// one normalise/round cycle in RND, then hold the result in DONE until the
// consumer takes it.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   in_valid / in_ready - operand handshake (ready only in IDLE)
//   x, y, roundmode     - operands and rounding mode
//   out_valid/out_ready - result handshake (valid only in DONE)
//   result, flags       - rounded product and {NV, OF, UF, NX}
module fmul_iter
    import fmul_pkg::*;
#(
    parameter int EW = 5,
    parameter int MW = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EW+MW:0]   x,
    input  logic [EW+MW:0]   y,
    input  logic [1:0]       roundmode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW:0]   result,
    output logic [3:0]       flags
);

    localparam int W  = 1 + EW + MW;
    localparam int PW = 2 * (MW + 1);
    localparam int CW = $clog2(MW + 1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(MW);
    localparam logic signed [EW+1:0] BIAS_S   = (EW + 2)'(fmul_bias(EW));
    localparam logic [W-1:0]         QNAN     = W'(fmul_qnan(EW, MW));

    state_e               state_q, state_d;
    logic [W-1:0]         x_q, x_d, y_q, y_d;
    logic [1:0]           rm_q, rm_d;
    logic                 sign_q, sign_d;
    logic signed [EW+1:0] exp_q, exp_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        prod_q, prod_d;
    logic [W-1:0]         result_q, result_d;
    logic [3:0]           flags_q, flags_d;

    logic [MW+1:0] addend_s;
    logic [MW+1:0] psum_s;
    logic [W-1:0]  rnd_res_s;
    logic [3:0]    rnd_flags_s;
    logic          sp_hit_s;
    logic [W-1:0]  sp_res_s;
    logic [3:0]    sp_flags_s;

    // Operand classification; subnormals count as zero.
    logic x_exp_ones_s, y_exp_ones_s, x_zero_s, y_zero_s;
    logic x_inf_s, y_inf_s, x_nan_s, y_nan_s, x_snan_s, y_snan_s, inv_s;
    assign x_exp_ones_s = &x_q[W-2:MW];
    assign y_exp_ones_s = &y_q[W-2:MW];
    assign x_zero_s     = ~|x_q[W-2:MW];
    assign y_zero_s     = ~|y_q[W-2:MW];
    assign x_inf_s      = x_exp_ones_s & ~|x_q[MW-1:0];
    assign y_inf_s      = y_exp_ones_s & ~|y_q[MW-1:0];
    assign x_nan_s      = x_exp_ones_s & |x_q[MW-1:0];
    assign y_nan_s      = y_exp_ones_s & |y_q[MW-1:0];
    assign x_snan_s     = x_nan_s & ~x_q[MW-1];
    assign y_snan_s     = y_nan_s & ~y_q[MW-1];
    assign inv_s        = (x_inf_s & y_zero_s) | (x_zero_s & y_inf_s);

    // Shift-add step: upper half accumulates the multiplicand when the
    // current multiplier bit (LSB of the lower half) is set, then the whole
    // product register shifts right by one.
    assign addend_s = prod_q[0] ? {1'b0, 1'b1, x_q[MW-1:0]} : {(MW + 2){1'b0}};
    assign psum_s   = {1'b0, prod_q[PW-1:MW+1]} + addend_s;

    fmul_round #(.EW(EW), .MW(MW)) u_round (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .prod_i   (prod_q),
        .rm_i     (rm_q),
        .result_o (rnd_res_s),
        .flags_o  (rnd_flags_s)
    );

    // Special-operand results that bypass the rounder.
    always_comb begin
        sp_hit_s   = 1'b1;
        sp_res_s   = QNAN;
        sp_flags_s = 4'b0000;
        if (x_nan_s | y_nan_s | inv_s) begin
            sp_res_s            = QNAN;
            sp_flags_s[FLAG_NV] = x_snan_s | y_snan_s | inv_s;
        end else if (x_inf_s | y_inf_s) begin
            sp_res_s = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
        end else if (x_zero_s | y_zero_s) begin
            sp_res_s = {sign_q, {(EW + MW){1'b0}}};
        end else begin
            sp_hit_s = 1'b0;
            sp_res_s = {W{1'b0}};
        end
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        rm_d     = rm_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y;
                    rm_d    = roundmode;
                    sign_d  = x[W-1] ^ y[W-1];
                    exp_d   = $signed({2'b00, x[W-2:MW]}) + $signed({2'b00, y[W-2:MW]}) - BIAS_S;
                    cnt_d   = {CW{1'b0}};
                    prod_d  = {{(MW + 1){1'b0}}, 1'b1, y[MW-1:0]};
                    state_d = ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                prod_d = {psum_s, prod_q[MW:1]};
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RND;
                end else begin
                    cnt_d = cnt_q + {{(CW - 1){1'b0}}, 1'b1};
                end
            end
            ST_RND: begin
                if (sp_hit_s) begin
                    result_d = sp_res_s;
                    flags_d  = sp_flags_s;
                end else begin
                    result_d = rnd_res_s;
                    flags_d  = rnd_flags_s;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x_q      <= {W{1'b0}};
            y_q      <= {W{1'b0}};
            rm_q     <= 2'b00;
            sign_q   <= 1'b0;
            exp_q    <= {(EW + 2){1'b0}};
            cnt_q    <= {CW{1'b0}};
            prod_q   <= {PW{1'b0}};
            result_q <= {W{1'b0}};
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rm_q     <= rm_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fmul_iter.sv
// Directed-vector bench for fmul_iter at default widths (half precision).
module tb_fmul_iter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  roundmode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    fmul_iter #(.EW(5), .MW(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .roundmode (roundmode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation, wait for out_valid (bounded), return what the DUT
    // shows and the number of edges after the accepting edge.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        x = a; y = b; roundmode = rm; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        r = result;
        f = flags;
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h flg=%b, expected 1 0 0000 0000",
                     in_ready, out_valid, result, flags);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] r; logic [3:0] f; int lat;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready: got %b expected 1", in_ready);
        end
        do_op(16'h3C00, 16'h3C00, 2'b01, r, f, lat);
        n_checks++;
        if (r !== 16'h3C00) begin n_fail++; $display("FAIL basic_result: got %h expected 3c00", r); end
        n_checks++;
        if (f !== 4'b0000) begin n_fail++; $display("FAIL basic_flags: got %b expected 0000", f); end
        n_checks++;
        if (lat !== 12) begin n_fail++; $display("FAIL basic_latency: got %0d expected 12", lat); end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    // Rounding, normalisation, overflow, specials and underflow vectors.
    task automatic test_vectors();
        logic [15:0] tx [0:21];
        logic [15:0] ty [0:21];
        logic [1:0]  trm [0:21];
        logic [15:0] tr [0:21];
        logic [3:0]  tf [0:21];
        logic [15:0] r; logic [3:0] f; int lat;
        tx  = '{16'h3C01, 16'h3C01, 16'h3C01, 16'h3C01, 16'h3C01, 16'h3C01, 16'h3E00, 16'hC000,
                16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF, 16'hFBFF, 16'hFBFF,
                16'h7C00, 16'h7E00, 16'h7D00, 16'h7C00, 16'h0000, 16'h0001, 16'h0400, 16'h8400};
        ty  = '{16'h3C01, 16'h3C01, 16'h3C01, 16'h3C01, 16'h3E00, 16'h3E00, 16'h3E00, 16'h4200,
                16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000,
                16'h0000, 16'h3C00, 16'h3C00, 16'hC000, 16'hBC00, 16'h3C00, 16'h3800, 16'h3800};
        trm = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 2'b01,
                2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11,
                2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        tr  = '{16'h3C02, 16'h3C03, 16'h3C02, 16'h3C02, 16'h3E02, 16'h3E01, 16'h4080, 16'hC600,
                16'h7C00, 16'h7BFF, 16'h7BFF, 16'h7C00, 16'hFC00, 16'hFBFF,
                16'h7E00, 16'h7E00, 16'h7E00, 16'hFC00, 16'h8000, 16'h0000, 16'h0000, 16'h8000};
        tf  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0011};
        for (int i = 0; i < 22; i++) begin
            do_op(tx[i], ty[i], trm[i], r, f, lat);
            n_checks++;
            if (r !== tr[i]) begin
                n_fail++;
                $display("FAIL vec[%0d] result (%h*%h rm=%b): got %h expected %h", i, tx[i], ty[i], trm[i], r, tr[i]);
            end
            n_checks++;
            if (f !== tf[i]) begin
                n_fail++;
                $display("FAIL vec[%0d] flags (%h*%h rm=%b): got %b expected %b", i, tx[i], ty[i], trm[i], f, tf[i]);
            end
            n_checks++;
            if (lat !== 12) begin
                n_fail++;
                $display("FAIL vec[%0d] latency: got %0d expected 12", i, lat);
            end
        end
    endtask

    // Stall in DONE, with ignored in_valid pulses during MUL.
    task automatic test_hold();
        int lat;
        out_ready = 1'b0;
        @(negedge clk);
        x = 16'h3C01; y = 16'h3C01; roundmode = 2'b01; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 x = 16'h7C00; y = 16'h0000; roundmode = 2'b11; in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_busy_ready: got %b expected 0", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 6;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        n_checks++;
        if (lat !== 12) begin n_fail++; $display("FAIL hold_latency: got %0d expected 12", lat); end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h3C02 || flags !== 4'b0001) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d]: got vld=%b rdy=%b res=%h flg=%b expected 1 0 3c02 0001",
                         c, out_valid, in_ready, result, flags);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    // Reset in the middle of MUL, then a clean operation.
    task automatic test_reset_mid();
        logic [15:0] r; logic [3:0] f; int lat;
        @(negedge clk);
        x = 16'h3C01; y = 16'h3C01; roundmode = 2'b01; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_state: got rdy=%b vld=%b res=%h flg=%b expected 1 0 0000 0000",
                     in_ready, out_valid, result, flags);
        end
        @(negedge clk);
        reset = 1'b0;
        do_op(16'h3C00, 16'h3C00, 2'b01, r, f, lat);
        n_checks++;
        if (r !== 16'h3C00) begin n_fail++; $display("FAIL reset_mid_result: got %h expected 3c00", r); end
        n_checks++;
        if (f !== 4'b0000) begin n_fail++; $display("FAIL reset_mid_flags: got %b expected 0000", f); end
        n_checks++;
        if (lat !== 12) begin n_fail++; $display("FAIL reset_mid_latency: got %0d expected 12", lat); end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        x         = 16'h0000;
        y         = 16'h0000;
        roundmode = 2'b00;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_vectors();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
